// File: rtl/prime_pkg.sv
// ---------------------------------------------------------------------------
// prime_pkg
// Shared definitions for the prime search engine: search modes, the control
// state encoding and the default build parameters (20-bit search space,
// 1 ms elapsed tick at 50 MHz).
// ---------------------------------------------------------------------------
package prime_pkg;

    // Search direction, sampled together with start
    localparam logic MODE_BELOW = 1'b0;   // largest prime strictly below limit
    localparam logic MODE_ABOVE = 1'b1;   // smallest prime strictly above limit

    // Default build parameters
    localparam int DEFAULT_WIDTH      = 20;
    localparam int DEFAULT_TICK_DIV   = 50000;
    localparam int DEFAULT_TIME_WIDTH = 20;

    // Control states of the search engine
    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_CAND,
        S_SETUP,
        S_DIV,
        S_CHECK,
        S_DONE
    } state_e;

endpackage

// File: rtl/prime_search_engine_if.sv
// ---------------------------------------------------------------------------
// prime_search_engine_if
// Request/result bundle between the input state machine (master) and the
// prime search engine (slave).
//   start, abort, mode, limit   : master -> engine
//   busy, done, found, prime,
//   elapsed                     : engine -> master / display path
// ---------------------------------------------------------------------------
interface prime_search_engine_if
    import prime_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int TIME_WIDTH = DEFAULT_TIME_WIDTH
);
    logic                  start;
    logic                  abort;
    logic                  mode;
    logic [WIDTH-1:0]      limit;
    logic                  busy;
    logic                  done;
    logic                  found;
    logic [WIDTH-1:0]      prime;
    logic [TIME_WIDTH-1:0] elapsed;

    modport master (
        output start, abort, mode, limit,
        input  busy, done, found, prime, elapsed
    );

    modport slave (
        input  start, abort, mode, limit,
        output busy, done, found, prime, elapsed
    );

endinterface

// File: rtl/prime_remainder.sv
// ---------------------------------------------------------------------------
// prime_remainder
// Restoring shift-subtract divider that only produces the remainder.
// A go pulse loads dividend/divisor; WIDTH shift-subtract steps follow and
// rem_valid pulses for one cycle together with the final remainder, WIDTH+1
// cycles after the go cycle. rem holds until the next go. clear cancels a
// division in flight so no stale rem_valid can leak into a later search.
// Ports:
//   clk, Reset_n : clock, asynchronous active-low reset
//   clear        : cancel the running division
//   go           : start a division (ignored while clear is high)
//   dividend     : WIDTH-bit dividend, sampled on go
//   divisor      : WIDTH-bit divisor (non-zero), sampled on go
//   rem          : remainder of the last completed division
//   rem_valid    : one-cycle pulse when rem is fresh
// ---------------------------------------------------------------------------
module prime_remainder
    import prime_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic             clear,
    input  logic             go,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem,
    output logic             rem_valid
);

    localparam int CNT_WIDTH = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     shift_q, shift_d;
    logic [WIDTH-1:0]     dsr_q, dsr_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 valid_q, valid_d;
    logic [WIDTH:0]       trial;

    // One restoring step per cycle: bring down the next dividend bit and
    // subtract the divisor whenever the partial remainder allows it. The
    // partial remainder always stays below the divisor, so the difference
    // fits back into WIDTH bits.
    always_comb begin
        rem_d   = rem_q;
        shift_d = shift_q;
        dsr_d   = dsr_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        trial   = {rem_q, shift_q[WIDTH-1]};
        if (clear) begin
            cnt_d = '0;
        end else if (go) begin
            rem_d   = '0;
            shift_d = dividend;
            dsr_d   = divisor;
            cnt_d   = CNT_WIDTH'(WIDTH);
        end else if (cnt_q != '0) begin
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
            if (trial >= {1'b0, dsr_q}) begin
                rem_d = trial[WIDTH-1:0] - dsr_q;
            end else begin
                rem_d = trial[WIDTH-1:0];
            end
            cnt_d = cnt_q - CNT_WIDTH'(1);
            if (cnt_q == CNT_WIDTH'(1)) begin
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rem_q   <= '0;
            shift_q <= '0;
            dsr_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            shift_q <= shift_d;
            dsr_q   <= dsr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign rem       = rem_q;
    assign rem_valid = valid_q;

endmodule

// File: rtl/prime_search_engine.sv
// ---------------------------------------------------------------------------
// prime_search_engine
// Searches for the largest prime below (mode 0) or the smallest prime above
// (mode 1) a WIDTH-bit limit by odd trial division, reports the result with
// a one-cycle done pulse and measures its own run time in elapsed ticks.
// Ports:
//   clk, Reset_n : clock, asynchronous active-low reset
//   bus (slave)  : start/abort/mode/limit in; busy/done/found/prime/elapsed
//                  out, all outputs registered
// Parameters:
//   WIDTH      : limit / candidate / divisor / prime width
//   TICK_DIV   : clk cycles per elapsed tick (>= 1)
//   TIME_WIDTH : elapsed counter width (saturating)
// ---------------------------------------------------------------------------
module prime_search_engine
    import prime_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int TICK_DIV   = DEFAULT_TICK_DIV,
    parameter int TIME_WIDTH = DEFAULT_TIME_WIDTH
) (
    input  logic                 clk,
    input  logic                 Reset_n,
    prime_search_engine_if.slave bus
);

    localparam int SQ_WIDTH  = 2 * WIDTH;
    localparam int PRE_WIDTH = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PRE_WIDTH-1:0]  PRE_LAST   = PRE_WIDTH'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0]      CAND_ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0]      CAND_TWO   = WIDTH'(2);
    localparam logic [WIDTH-1:0]      CAND_THREE = WIDTH'(3);
    localparam logic [WIDTH-1:0]      CAND_MAX   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]      DIV_FIRST  = WIDTH'(3);
    localparam logic [SQ_WIDTH-1:0]   SQ_FIRST   = SQ_WIDTH'(9);
    localparam logic [SQ_WIDTH-1:0]   SQ_FOUR    = SQ_WIDTH'(4);
    localparam logic [TIME_WIDTH-1:0] TIME_MAX   = {TIME_WIDTH{1'b1}};

    state_e                state_q, state_d;
    logic                  mode_q, mode_d;
    logic [WIDTH-1:0]      limit_q, limit_d;
    logic [WIDTH-1:0]      cand_q, cand_d;
    logic [WIDTH-1:0]      div_q, div_d;
    logic [SQ_WIDTH-1:0]   sq_q, sq_d;
    logic                  go_q, go_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  found_q, found_d;
    logic [WIDTH-1:0]      prime_q, prime_d;
    logic [PRE_WIDTH-1:0]  pre_q, pre_d;
    logic [TIME_WIDTH-1:0] elapsed_q, elapsed_d;

    logic                  abort_hit;
    logic                  start_accept;
    logic [WIDTH-1:0]      step_cand;
    logic                  step_end;
    logic                  fin;
    logic                  fin_found;
    logic [SQ_WIDTH-1:0]   div_x4;
    logic [WIDTH-1:0]      rem;
    logic                  rem_valid;

    // Abort only matters while a search is running; it also cancels the
    // divider so a late rem_valid cannot be taken by the next search.
    assign abort_hit    = bus.abort && busy_q;
    assign start_accept = (state_q == S_IDLE) && bus.start;
    assign div_x4       = {{(WIDTH - 2){1'b0}}, div_q, 2'b00};

    prime_remainder #(
        .WIDTH (WIDTH)
    ) u_remainder (
        .clk       (clk),
        .Reset_n   (Reset_n),
        .clear     (abort_hit),
        .go        (go_q),
        .dividend  (cand_q),
        .divisor   (div_q),
        .rem       (rem),
        .rem_valid (rem_valid)
    );

    // Next candidate in the search direction and whether stepping would run
    // off the end of the number range (below 2, or past all-ones).
    always_comb begin
        if (mode_q == MODE_ABOVE) begin
            step_cand = cand_q + CAND_ONE;
            step_end  = (cand_q == CAND_MAX);
        end else begin
            step_cand = cand_q - CAND_ONE;
            step_end  = (cand_q < CAND_TWO);
        end
    end

    // Search control. Trial division walks odd divisors d = 3, 5, 7, ...
    // while d*d <= candidate; d*d is tracked incrementally as sq, since
    // (d+2)^2 = d^2 + 4d + 4. Every path that ends the search funnels through
    // fin so the result registers and the done pulse update in one place.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        limit_d   = limit_q;
        cand_d    = cand_q;
        div_d     = div_q;
        sq_d      = sq_q;
        go_d      = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        found_d   = found_q;
        prime_d   = prime_q;
        fin       = 1'b0;
        fin_found = 1'b0;

        if (abort_hit) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_d = S_INIT;
                        mode_d  = bus.mode;
                        limit_d = bus.limit;
                        busy_d  = 1'b1;
                    end
                end
                S_INIT: begin
                    if (mode_q == MODE_BELOW) begin
                        if (limit_q == '0) begin
                            fin = 1'b1;
                        end else begin
                            cand_d  = limit_q - CAND_ONE;
                            state_d = S_CAND;
                        end
                    end else begin
                        if (limit_q == CAND_MAX) begin
                            fin = 1'b1;
                        end else begin
                            cand_d  = limit_q + CAND_ONE;
                            state_d = S_CAND;
                        end
                    end
                end
                S_CAND: begin
                    if ((cand_q == CAND_TWO) || (cand_q == CAND_THREE)) begin
                        fin       = 1'b1;
                        fin_found = 1'b1;
                    end else if ((cand_q < CAND_TWO) || !cand_q[0]) begin
                        if (step_end) begin
                            fin = 1'b1;
                        end else begin
                            cand_d = step_cand;
                        end
                    end else begin
                        div_d   = DIV_FIRST;
                        sq_d    = SQ_FIRST;
                        state_d = S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (sq_q > {{WIDTH{1'b0}}, cand_q}) begin
                        fin       = 1'b1;
                        fin_found = 1'b1;
                    end else begin
                        go_d    = 1'b1;
                        state_d = S_DIV;
                    end
                end
                S_DIV: begin
                    if (rem_valid) begin
                        state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (rem == '0) begin
                        if (step_end) begin
                            fin = 1'b1;
                        end else begin
                            cand_d  = step_cand;
                            state_d = S_CAND;
                        end
                    end else begin
                        sq_d    = sq_q + div_x4 + SQ_FOUR;
                        div_d   = div_q + CAND_TWO;
                        state_d = S_SETUP;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase

            if (fin) begin
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                found_d = fin_found;
                prime_d = fin_found ? cand_q : '0;
            end
        end
    end

    // Elapsed timer: the prescaler runs on every busy cycle and rolls the
    // saturating tick counter every TICK_DIV cycles. Both restart on an
    // accepted start and simply freeze once busy drops.
    always_comb begin
        pre_d     = pre_q;
        elapsed_d = elapsed_q;
        if (start_accept) begin
            pre_d     = '0;
            elapsed_d = '0;
        end else if (busy_q) begin
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
                if (elapsed_q != TIME_MAX) begin
                    elapsed_d = elapsed_q + TIME_WIDTH'(1);
                end
            end else begin
                pre_d = pre_q + PRE_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            mode_q    <= MODE_BELOW;
            limit_q   <= '0;
            cand_q    <= '0;
            div_q     <= '0;
            sq_q      <= '0;
            go_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            found_q   <= 1'b0;
            prime_q   <= '0;
            pre_q     <= '0;
            elapsed_q <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            limit_q   <= limit_d;
            cand_q    <= cand_d;
            div_q     <= div_d;
            sq_q      <= sq_d;
            go_q      <= go_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            found_q   <= found_d;
            prime_q   <= prime_d;
            pre_q     <= pre_d;
            elapsed_q <= elapsed_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.found   = found_q;
    assign bus.prime   = prime_q;
    assign bus.elapsed = elapsed_q;

endmodule

// File: tb/tb_prime_search_engine.sv
// ---------------------------------------------------------------------------
// tb_prime_search_engine
// Directed bench for prime_search_engine with hand-computed results; the
// elapsed timer runs with TICK_DIV = 4 so its value can be derived from the
// number of busy cycles the bench observes.
// ---------------------------------------------------------------------------
module tb_prime_search_engine;
    import prime_pkg::*;

    localparam int WIDTH      = 20;
    localparam int TICK_DIV   = 4;
    localparam int TIME_WIDTH = 20;
    localparam int MAX_CYCLES = 20000;

    logic clk = 1'b0;
    logic Reset_n;

    int checks = 0;
    int errors = 0;

    int   run_cycles;
    int   run_busy;
    int   run_busy_drop;
    logic run_done;

    always #5 clk = ~clk;

    prime_search_engine_if #(
        .WIDTH      (WIDTH),
        .TIME_WIDTH (TIME_WIDTH)
    ) bus ();

    prime_search_engine #(
        .WIDTH      (WIDTH),
        .TICK_DIV   (TICK_DIV),
        .TIME_WIDTH (TIME_WIDTH)
    ) dut (
        .clk     (clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Issue one start and follow the search until done or the cycle budget
    // runs out, counting busy cycles. Optionally fires a second start (with a
    // different limit/mode) at cycle restart_at, which the engine must ignore.
    task automatic applyStimulus(input logic m, input logic [WIDTH-1:0] lim,
                                 input int restart_at);
        @(posedge clk); #1;
        bus.mode  = m;
        bus.limit = lim;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start     = 1'b0;
        run_cycles    = 1;
        run_busy      = 0;
        run_busy_drop = 0;
        while (!bus.done && run_cycles < MAX_CYCLES) begin
            if (bus.busy) run_busy++;
            else run_busy_drop++;
            bus.start = (run_cycles == restart_at);
            if (run_cycles == restart_at) begin
                bus.limit = 20'd13;
                bus.mode  = MODE_ABOVE;
            end
            @(posedge clk); #1;
            run_cycles++;
        end
        bus.start = 1'b0;
        run_done  = bus.done;
    endtask

    // Full search with result, busy profile, elapsed and done-pulse checks
    task automatic runSearch(input string tag, input logic m,
                             input logic [WIDTH-1:0] lim, input logic exp_found,
                             input logic [WIDTH-1:0] exp_prime, input int restart_at);
        int exp_elapsed;
        applyStimulus(m, lim, restart_at);
        exp_elapsed = run_busy / TICK_DIV;
        checkOutput({tag, " done"}, 64'(run_done), 64'(1));
        checkOutput({tag, " found"}, 64'(bus.found), 64'(exp_found));
        checkOutput({tag, " prime"}, 64'(bus.prime), 64'(exp_prime));
        checkOutput({tag, " busy_at_done"}, 64'(bus.busy), 64'(0));
        checkOutput({tag, " busy_dropped"}, 64'(run_busy_drop), 64'(0));
        checkOutput({tag, " elapsed"}, 64'(bus.elapsed), 64'(exp_elapsed));
        @(posedge clk); #1;
        checkOutput({tag, " done_pulse"}, 64'(bus.done), 64'(0));
        checkOutput({tag, " elapsed_hold"}, 64'(bus.elapsed), 64'(exp_elapsed));
        checkOutput({tag, " prime_hold"}, 64'(bus.prime), 64'(exp_prime));
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   seen_done;
        Reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.mode  = MODE_BELOW;
        bus.limit = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy", 64'(bus.busy), 64'(0));
        checkOutput("reset done", 64'(bus.done), 64'(0));
        checkOutput("reset found", 64'(bus.found), 64'(0));
        checkOutput("reset prime", 64'(bus.prime), 64'(0));
        checkOutput("reset elapsed", 64'(bus.elapsed), 64'(0));
        Reset_n = 1'b1;

        // Minimum latency: 3 below -> 2, done on the third edge from start
        runSearch("below3", MODE_BELOW, 20'd3, 1'b1, 20'd2, 0);
        checkOutput("below3 latency", 64'(run_cycles), 64'(3));

        // 13 above: 14 even, 15 = 3*5, 16 even, 17 prime
        runSearch("above13", MODE_ABOVE, 20'd13, 1'b1, 20'd17, 0);

        // Range ends
        runSearch("below2", MODE_BELOW, 20'd2, 1'b0, 20'd0, 0);
        runSearch("below0", MODE_BELOW, 20'd0, 1'b0, 20'd0, 0);
        runSearch("above_max", MODE_ABOVE, 20'd1048575, 1'b0, 20'd0, 0);
        runSearch("below_max", MODE_BELOW, 20'd1048575, 1'b1, 20'd1048573, 0);

        // Longer run with a second start mid-search that must be ignored
        runSearch("below1000", MODE_BELOW, 20'd1000, 1'b1, 20'd997, 20);

        // Prior result for the abort sequence
        runSearch("below100", MODE_BELOW, 20'd100, 1'b1, 20'd97, 0);

        // Abort 10 cycles into a long search: 10 busy cycles -> elapsed 2
        @(posedge clk); #1;
        bus.mode  = MODE_BELOW;
        bus.limit = 20'd100000;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        checkOutput("abort busy", 64'(bus.busy), 64'(0));
        checkOutput("abort done", 64'(bus.done), 64'(0));
        checkOutput("abort elapsed", 64'(bus.elapsed), 64'(2));
        seen_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) seen_done++;
        end
        checkOutput("abort no_done", 64'(seen_done), 64'(0));
        checkOutput("abort prime", 64'(bus.prime), 64'(97));
        checkOutput("abort found", 64'(bus.found), 64'(1));
        checkOutput("abort elapsed_hold", 64'(bus.elapsed), 64'(2));
        checkOutput("abort still_idle", 64'(bus.busy), 64'(0));

        // Asynchronous reset in the middle of a search
        bus.limit = 20'd100000;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("midrun busy", 64'(bus.busy), 64'(1));
        #2;
        Reset_n = 1'b0;
        #1;
        checkOutput("async_reset busy", 64'(bus.busy), 64'(0));
        checkOutput("async_reset done", 64'(bus.done), 64'(0));
        checkOutput("async_reset found", 64'(bus.found), 64'(0));
        checkOutput("async_reset prime", 64'(bus.prime), 64'(0));
        checkOutput("async_reset elapsed", 64'(bus.elapsed), 64'(0));
        @(posedge clk); #1;
        Reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("post_reset busy", 64'(bus.busy), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
